// File: rtl/pulse_train_checker.sv
// Receive-side pulse train monitor: synchronises pulse_i, measures high width and
// rising-to-rising spacing, and raises sticky flags on limit or timeout violations.
module pulse_train_checker #(
  parameter int g_sync_stages = 2,
  parameter int g_cnt_width   = 16,
  parameter int g_min_width   = 2,
  parameter int g_max_width   = 8,
  parameter int g_min_spacing = 40,
  parameter int g_max_spacing = 80
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_i,
  input  logic                   enable_i,
  input  logic                   pulse_i,
  input  logic                   clear_i,
  output logic [g_cnt_width-1:0] width_o,
  output logic [g_cnt_width-1:0] spacing_o,
  output logic                   meas_valid_o,
  output logic [31:0]            pulse_count_o,
  output logic                   err_width_o,
  output logic                   err_spacing_o,
  output logic                   err_timeout_o
);

  localparam int W = g_cnt_width;
  localparam logic [W-1:0] ZERO        = {W{1'b0}};
  localparam logic [W-1:0] ONE         = W'(1);
  localparam logic [W-1:0] CNT_MAX     = {W{1'b1}};
  localparam logic [W-1:0] MIN_W       = W'(g_min_width);
  localparam logic [W-1:0] MAX_W       = W'(g_max_width);
  localparam logic [W-1:0] MIN_S       = W'(g_min_spacing);
  localparam logic [W-1:0] MAX_S       = W'(g_max_spacing);
  localparam logic [W-1:0] TIMEOUT_CNT = W'(g_max_spacing + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t                   state_r, state_nxt_s;
  logic [g_sync_stages-1:0] sync_r;
  logic                     p_s, p_d_r, rise_s, fall_s;
  logic                     start_s, done_s, timeout_s;
  logic [W-1:0]             width_cnt_r, spacing_cnt_r, spc_lat_r;
  logic                     first_r;
  logic                     cap_vld_r, dly_vld_r;
  logic [W-1:0]             cap_w_r, cap_s_r, dly_w_r, dly_s_r;
  logic                     w_bad_s, s_bad_s;

  assign p_s    = sync_r[g_sync_stages-1];
  assign rise_s = p_s & ~p_d_r;
  assign fall_s = ~p_s & p_d_r;

  // Synchroniser chain and one-cycle delayed copy for edge detection
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      sync_r <= {g_sync_stages{1'b0}};
      p_d_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[g_sync_stages-2:0], pulse_i};
      p_d_r  <= p_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a disable always wins and drops the pulse in flight
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    done_s      = 1'b0;
    timeout_s   = 1'b0;
    if (!enable_i) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (rise_s) begin
            state_nxt_s = S_HIGH;
            start_s     = 1'b1;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_HIGH: begin
          if (fall_s) begin
            state_nxt_s = S_LOW;
            done_s      = 1'b1;
          end else begin
            state_nxt_s = S_HIGH;
          end
        end
        S_LOW: begin
          timeout_s = (spacing_cnt_r == TIMEOUT_CNT);
          if (rise_s) begin
            state_nxt_s = S_HIGH;
            start_s     = 1'b1;
          end else begin
            state_nxt_s = S_LOW;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // Saturating width/spacing counters and spacing latch taken at each rise
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      width_cnt_r   <= ZERO;
      spacing_cnt_r <= ZERO;
      spc_lat_r     <= ZERO;
      first_r       <= 1'b1;
    end else begin
      if (start_s) begin
        width_cnt_r   <= ONE;
        spacing_cnt_r <= ONE;
        spc_lat_r     <= first_r ? ZERO : spacing_cnt_r;
      end else begin
        if (state_r == S_HIGH && p_s && width_cnt_r != CNT_MAX) begin
          width_cnt_r <= width_cnt_r + ONE;
        end
        if (state_r != S_IDLE && spacing_cnt_r != CNT_MAX) begin
          spacing_cnt_r <= spacing_cnt_r + ONE;
        end
      end
      if (!enable_i) begin
        first_r <= 1'b1;
      end else if (start_s) begin
        first_r <= 1'b0;
      end
    end
  end

  // Two-stage measurement pipeline placing the strobe g_sync_stages+2 cycles after pulse_i falls
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      cap_vld_r <= 1'b0;
      cap_w_r   <= ZERO;
      cap_s_r   <= ZERO;
      dly_vld_r <= 1'b0;
      dly_w_r   <= ZERO;
      dly_s_r   <= ZERO;
    end else begin
      cap_vld_r <= done_s;
      if (done_s) begin
        cap_w_r <= width_cnt_r;
        cap_s_r <= spc_lat_r;
      end
      dly_vld_r <= cap_vld_r;
      dly_w_r   <= cap_w_r;
      dly_s_r   <= cap_s_r;
    end
  end

  assign w_bad_s = dly_vld_r && (dly_w_r < MIN_W || dly_w_r > MAX_W);
  assign s_bad_s = dly_vld_r && (dly_s_r != ZERO) && (dly_s_r < MIN_S || dly_s_r > MAX_S);

  // Measurement outputs, pulse counter and sticky flags; a new event beats clear_i
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      meas_valid_o  <= 1'b0;
      width_o       <= ZERO;
      spacing_o     <= ZERO;
      pulse_count_o <= 32'd0;
      err_width_o   <= 1'b0;
      err_spacing_o <= 1'b0;
      err_timeout_o <= 1'b0;
    end else begin
      meas_valid_o <= dly_vld_r;
      if (dly_vld_r) begin
        width_o       <= dly_w_r;
        spacing_o     <= dly_s_r;
        pulse_count_o <= clear_i ? 32'd1 : pulse_count_o + 32'd1;
      end else if (clear_i) begin
        pulse_count_o <= 32'd0;
      end
      if (w_bad_s) begin
        err_width_o <= 1'b1;
      end else if (clear_i) begin
        err_width_o <= 1'b0;
      end
      if (s_bad_s) begin
        err_spacing_o <= 1'b1;
      end else if (clear_i) begin
        err_spacing_o <= 1'b0;
      end
      if (timeout_s) begin
        err_timeout_o <= 1'b1;
      end else if (clear_i) begin
        err_timeout_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_train_checker.sv
// Bench for pulse_train_checker: an event-level reference model (timestamps of
// accepted rises/falls) is compared every cycle, plus directed literal checks.
module tb_pulse_train_checker;
  localparam int G    = 2;
  localparam int W    = 16;
  localparam int MINW = 2;
  localparam int MAXW = 8;
  localparam int MINS = 40;
  localparam int MAXS = 80;
  localparam int SATV = 65535;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic pulse = 1'b0;
  logic clear = 1'b0;
  logic [W-1:0] width_o, spacing_o;
  logic meas_valid_o;
  logic [31:0] pulse_count_o;
  logic err_width_o, err_spacing_o, err_timeout_o;

  int total = 0;
  int bad = 0;
  int prints = 0;

  always #5 clk = ~clk;

  pulse_train_checker #(
    .g_sync_stages(G), .g_cnt_width(W), .g_min_width(MINW), .g_max_width(MAXW),
    .g_min_spacing(MINS), .g_max_spacing(MAXS)
  ) dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .enable_i(enable), .pulse_i(pulse),
    .clear_i(clear), .width_o(width_o), .spacing_o(spacing_o),
    .meas_valid_o(meas_valid_o), .pulse_count_o(pulse_count_o),
    .err_width_o(err_width_o), .err_spacing_o(err_spacing_o),
    .err_timeout_o(err_timeout_o)
  );

  // ---------------- reference model ----------------
  typedef struct {int due; int w; int s;} pend_t;
  pend_t pq[$];
  logic hist [0:G];
  int   ecount = 0;
  bit   m_idle, m_high, m_first;
  int   rise_e, last_e, cur_spc;
  bit   m_valid;
  int   m_width, m_spacing;
  logic [31:0] m_count;
  bit   m_ew, m_es, m_et;

  function automatic int sat(input int v);
    return (v > SATV) ? SATV : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= G; i++) hist[i] = 1'b0;
    pq.delete();
    m_idle = 1; m_high = 0; m_first = 1;
    rise_e = 0; last_e = 0; cur_spc = 0;
    m_valid = 0; m_width = 0; m_spacing = 0; m_count = 32'd0;
    m_ew = 0; m_es = 0; m_et = 0;
  endtask

  task automatic model_step();
    bit rise, fall, ews, ess, ets, cev, do_start;
    int e;
    pend_t p;
    ecount++;
    e = ecount;
    // the synchronised level seen by the monitor lags pulse_i by G edges
    rise = hist[G-1] && !hist[G];
    fall = !hist[G-1] && hist[G];
    ews = 0; ess = 0; ets = 0; cev = 0; do_start = 0;
    m_valid = 0;
    if (pq.size() > 0 && pq[0].due == e) begin
      p = pq.pop_front();
      m_valid = 1; m_width = p.w; m_spacing = p.s; cev = 1;
      ews = (p.w < MINW) || (p.w > MAXW);
      ess = (p.s != 0) && ((p.s < MINS) || (p.s > MAXS));
    end
    if (!enable) begin
      m_idle = 1; m_high = 0; m_first = 1;
    end else if (m_idle) begin
      do_start = rise;
    end else if (m_high) begin
      if (fall) begin
        p.due = e + 2; p.w = sat(e - rise_e); p.s = cur_spc;
        pq.push_back(p);
        m_high = 0;
      end
    end else begin
      if (e - last_e == MAXS + 1) ets = 1;
      do_start = rise;
    end
    if (do_start) begin
      cur_spc = m_first ? 0 : sat(e - last_e);
      rise_e = e; last_e = e; m_first = 0; m_idle = 0; m_high = 1;
    end
    if (cev) m_count = clear ? 32'd1 : m_count + 32'd1;
    else if (clear) m_count = 32'd0;
    m_ew = ews ? 1'b1 : (clear ? 1'b0 : m_ew);
    m_es = ess ? 1'b1 : (clear ? 1'b0 : m_es);
    m_et = ets ? 1'b1 : (clear ? 1'b0 : m_et);
    for (int i = G; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pulse;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      total++;
      if (meas_valid_o !== m_valid || width_o !== W'(m_width) || spacing_o !== W'(m_spacing) ||
          pulse_count_o !== m_count || err_width_o !== m_ew || err_spacing_o !== m_es ||
          err_timeout_o !== m_et) begin
        bad++;
        if (prints < 30) begin
          prints++;
          $display("FAIL model_cmp t=%0t got v=%0b w=%0d s=%0d c=%0d ew=%0b es=%0b et=%0b want v=%0b w=%0d s=%0d c=%0d ew=%0b es=%0b et=%0b",
                   $time, meas_valid_o, width_o, spacing_o, pulse_count_o, err_width_o, err_spacing_o, err_timeout_o,
                   m_valid, m_width, m_spacing, m_count, m_ew, m_es, m_et);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic send(input int hi, input int per);
    pulse = 1'b1;
    repeat (hi) @(negedge clk);
    pulse = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  task automatic gap_clear();
    enable = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic rstep();
    clear  = ($urandom_range(0, 39) == 0);
    enable = ($urandom_range(0, 49) != 0);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, per;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_count", pulse_count_o, 32'd0);
    check("rst_flags", {29'd0, err_width_o, err_spacing_o, err_timeout_o}, 32'd0);
    check("rst_outs", {15'd0, meas_valid_o, width_o | spacing_o}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: regular 4-wide pulses every 50 cycles, plus strobe latency
    enable = 1'b1;
    pulse = 1'b1;
    repeat (4) @(negedge clk);
    pulse = 1'b0;
    repeat (4) @(negedge clk);
    check("t1_lat_early", {31'd0, meas_valid_o}, 32'd0);
    @(negedge clk);
    check("t1_lat_valid", {31'd0, meas_valid_o}, 32'd1);
    check("t1_first_w", {16'd0, width_o}, 32'd4);
    check("t1_first_s", {16'd0, spacing_o}, 32'd0);
    repeat (41) @(negedge clk);
    repeat (4) send(4, 50);
    check("t1_count", pulse_count_o, 32'd5);
    check("t1_w", {16'd0, width_o}, 32'd4);
    check("t1_s", {16'd0, spacing_o}, 32'd50);
    check("t1_flags", {29'd0, err_width_o, err_spacing_o, err_timeout_o}, 32'd0);

    // 2: width violations are sticky until cleared
    gap_clear();
    enable = 1'b1;
    send(1, 50);
    check("t2_ew_short", {31'd0, err_width_o}, 32'd1);
    send(12, 50);
    check("t2_w12", {16'd0, width_o}, 32'd12);
    check("t2_ew_held", {31'd0, err_width_o}, 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t2_ew_clr", {31'd0, err_width_o}, 32'd0);

    // 3: too-short then too-long spacing with timeout
    gap_clear();
    enable = 1'b1;
    send(4, 30);
    send(4, 90);
    check("t3_es", {31'd0, err_spacing_o}, 32'd1);
    check("t3_et", {31'd0, err_timeout_o}, 32'd1);
    send(4, 50);
    check("t3_s90", {16'd0, spacing_o}, 32'd90);

    // 4: disable mid-pulse and re-enable while high
    gap_clear();
    enable = 1'b1;
    pulse = 1'b1;
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    pulse = 1'b0;
    repeat (30) @(negedge clk);
    check("t4_no_strobe", pulse_count_o, 32'd0);
    send(4, 50);
    check("t4_count", pulse_count_o, 32'd1);
    check("t4_s0", {16'd0, spacing_o}, 32'd0);

    // 5: clear coinciding with a width-violating strobe
    gap_clear();
    enable = 1'b1;
    send(4, 50);
    pulse = 1'b1;
    repeat (12) @(negedge clk);
    pulse = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t5_count", pulse_count_o, 32'd1);
    check("t5_ew", {31'd0, err_width_o}, 32'd1);
    check("t5_s50", {16'd0, spacing_o}, 32'd50);

    // 6: asynchronous reset mid-pulse
    gap_clear();
    enable = 1'b1;
    send(4, 50);
    pulse = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_count", pulse_count_o, 32'd0);
    check("t6_outs", {15'd0, meas_valid_o, width_o | spacing_o}, 32'd0);
    @(negedge clk);
    pulse = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(4, 50);
    send(4, 50);
    check("t6_count2", pulse_count_o, 32'd2);
    check("t6_w", {16'd0, width_o}, 32'd4);
    check("t6_s", {16'd0, spacing_o}, 32'd50);

    // Random pulse trains with random clears and enable drops
    gap_clear();
    enable = 1'b1;
    for (int n = 0; n < 40; n++) begin
      hi  = $urandom_range(1, 10);
      per = hi + $urandom_range(1, 90);
      pulse = 1'b1;
      repeat (hi) rstep();
      pulse = 1'b0;
      repeat (per - hi) rstep();
    end
    clear = 1'b0;
    enable = 1'b1;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
